// File: rtl/sample_loader_pkg.sv
// Shared project definitions for the sample loader and fir_pipelined:
// default widths, the minimum job length and the loader state encoding.
package sample_loader_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int MIN_COUNT  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

endpackage

// File: rtl/sample_loader.sv
// Streams cfg_count samples into the sample memory at cfg_in_base, then
// kicks the FIR once and waits for a fresh rising edge of fir_done.
module sample_loader
  import sample_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic [ADDR_W-1:0] cfg_count,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              fir_start,
  output logic [ADDR_W-1:0] fir_in_addr,
  output logic [ADDR_W-1:0] fir_out_addr,
  output logic [ADDR_W-1:0] fir_count,
  input  logic              fir_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;
  logic              err_q, err_d;
  logic              fir_done_q;
  logic              s_ready_q, busy_q, fir_start_q, done_q;

  logic accept;
  logic fir_rise;
  logic too_short;

  assign accept    = s_valid && s_ready_q;
  assign fir_rise  = fir_done && !fir_done_q;
  assign too_short = cfg_count < ADDR_W'(MIN_COUNT);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d    = state_q;
    idx_d      = idx_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    count_d    = count_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          in_base_d  = cfg_in_base;
          out_base_d = cfg_out_base;
          count_d    = cfg_count;
          idx_d      = '0;
          err_d      = too_short;
          state_d    = too_short ? ST_FIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          mem_we_d   = 1'b1;
          mem_addr_d = in_base_q + idx_q;
          mem_data_d = s_data;
          idx_d      = idx_q + ADDR_W'(1);
          if (idx_q == count_q - ADDR_W'(1)) state_d = ST_FLUSH;
        end
      end
      // One idle cycle lets the final registered write retire before the FIR starts.
      ST_FLUSH: state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (fir_rise) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they are registered yet exact per state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      in_base_q   <= '0;
      out_base_q  <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      err_q       <= 1'b0;
      fir_done_q  <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      fir_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_base_q   <= in_base_d;
      out_base_q  <= out_base_d;
      count_q     <= count_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_we_q    <= mem_we_d;
      err_q       <= err_d;
      fir_done_q  <= fir_done;
      s_ready_q   <= (state_d == ST_LOAD);
      busy_q      <= (state_d != ST_IDLE);
      fir_start_q <= (state_d == ST_START);
      done_q      <= (state_d == ST_FIN);
    end
  end

  assign s_ready      = s_ready_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign mem_we       = mem_we_q;
  assign fir_start    = fir_start_q;
  assign fir_in_addr  = in_base_q;
  assign fir_out_addr = out_base_q;
  assign fir_count    = count_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sample_loader.sv
// Self-checking bench for sample_loader: a table of jobs plus random jobs,
// each compared against a list-of-writes model, and a mid-job reset sequence.
module tb_sample_loader;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic [AW-1:0] cfg_in_base = '0;
  logic [AW-1:0] cfg_out_base = '0;
  logic [AW-1:0] cfg_count = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic          fir_start;
  logic [AW-1:0] fir_in_addr, fir_out_addr, fir_count;
  logic          fir_done = 1'b0;
  logic          busy, done, err;

  sample_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .cfg_in_base  (cfg_in_base),
    .cfg_out_base (cfg_out_base),
    .cfg_count    (cfg_count),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .fir_start    (fir_start),
    .fir_in_addr  (fir_in_addr),
    .fir_out_addr (fir_out_addr),
    .fir_count    (fir_count),
    .fir_done     (fir_done),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] in_base;
    logic [AW-1:0] out_base;
    logic [AW-1:0] count;
    int            gap;      // 0 back-to-back, 1 alternate cycles, 2 random gaps
    bit            ramp;     // samples 1..count instead of random
    int            held;     // cycles fir_done stays high into WAIT
    bit            exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Passive monitor: logs every write and counts pulses.
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int start_cnt = 0;
  int done_cnt  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_data);
      end
      if (fir_start) start_cnt <= start_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic present_beat(input logic [DW-1:0] d, output bit rdy);
    int to;
    s_valid = 1'b1;
    s_data  = d;
    to = 0;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk); #1;
      arm = 1'b0;
      to++;
    end while (!rdy && to < 20);
  endtask

  task automatic run_job(input vec_t v, input string tag);
    logic [DW-1:0] samp[$];
    int  b_wr, b_st, b_dn, to, n;
    bit  rdy, seen;
    n    = int'(v.count);
    b_wr = wr_addr.size();
    b_st = start_cnt;
    b_dn = done_cnt;
    for (int i = 0; i < n; i++) samp.push_back(v.ramp ? DW'(i + 1) : DW'($urandom));

    @(posedge clk); #1;
    arm = 1'b1; cfg_in_base = v.in_base; cfg_out_base = v.out_base; cfg_count = v.count;
    @(posedge clk); #1;
    arm = 1'b0;
    cfg_in_base = AW'($urandom); cfg_out_base = AW'($urandom); cfg_count = AW'($urandom);

    if (v.exp_err) begin
      @(negedge clk);
      check({tag, "_err_set"}, err, 1);
      check({tag, "_err_done"}, done, 1);
      check({tag, "_err_sready"}, s_ready, 0);
      @(negedge clk);
      check({tag, "_err_done_end"}, done, 0);
      check({tag, "_err_idle"}, busy, 0);
      check({tag, "_err_sticky"}, err, 1);
      @(posedge clk); #1;
      check({tag, "_err_nowr"}, wr_addr.size() - b_wr, 0);
      check({tag, "_err_nostart"}, start_cnt - b_st, 0);
      check({tag, "_err_ndone"}, done_cnt - b_dn, 1);
      return;
    end

    @(negedge clk);
    check({tag, "_err_clear"}, err, 0);
    check({tag, "_sready_load"}, s_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < n; i++) begin
      int gaps;
      gaps = (v.gap == 1) ? ((i > 0) ? 1 : 0) :
             (v.gap == 2) ? int'($urandom_range(0, 3)) : 0;
      s_valid = 1'b0;
      repeat (gaps) begin @(posedge clk); #1; end
      if (i == 1) begin
        // arm mid-load must be ignored
        arm = 1'b1; cfg_in_base = v.in_base + AW'(100); cfg_count = AW'(1);
      end
      present_beat(samp[i], rdy);
      if (!rdy) begin
        check({tag, "_beat_timeout"}, rdy, 1);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;

    @(negedge clk);
    check({tag, "_sready_flush"}, s_ready, 0);
    check({tag, "_last_we"}, mem_we, 1);
    check({tag, "_last_addr"}, mem_addr, (int'(v.in_base) + n - 1) % (1 << AW));

    seen = 1'b0; to = 0;
    while (!seen && to < 10) begin
      @(negedge clk);
      seen = fir_start;
      to++;
    end
    check({tag, "_start_seen"}, seen, 1);
    check({tag, "_wr_before_start"}, wr_addr.size() - b_wr, n);
    check({tag, "_we_at_start"}, mem_we, 0);
    check({tag, "_fir_in"}, fir_in_addr, v.in_base);
    check({tag, "_fir_out"}, fir_out_addr, v.out_base);
    check({tag, "_fir_cnt"}, fir_count, v.count);

    @(posedge clk); #1;
    if (v.held > 0) begin
      repeat (v.held) @(posedge clk);
      #1;
      check({tag, "_held_nodone"}, done_cnt - b_dn, 0);
      check({tag, "_held_busy"}, busy, 1);
    end
    fir_done = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check({tag, "_wait_busy"}, busy, 1);
    fir_done = 1'b1;
    @(negedge clk);
    check({tag, "_done_early"}, done, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_fir_in_hold"}, fir_in_addr, v.in_base);
    @(negedge clk);
    check({tag, "_done_end"}, done, 0);
    check({tag, "_idle"}, busy, 0);

    check({tag, "_nwr"}, wr_addr.size() - b_wr, n);
    check({tag, "_nstart"}, start_cnt - b_st, 1);
    for (int i = 0; i < n; i++) begin
      if (b_wr + i < wr_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, i), wr_addr[b_wr + i], (int'(v.in_base) + i) % (1 << AW));
        check($sformatf("%s_data%0d", tag, i), wr_data[b_wr + i], samp[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t rv;
    vec_t tail;
    bit   rdy;
    int   n_wr, n_st;

    vecs.push_back('{10'h010, 10'h100, 10'd5, 0, 1'b1, 0, 1'b0});
    vecs.push_back('{10'h020, 10'h120, 10'd2, 0, 1'b0, 0, 1'b1});
    vecs.push_back('{10'h030, 10'h130, 10'd4, 0, 1'b0, 0, 1'b0});
    vecs.push_back('{10'h3FE, 10'h000, 10'd4, 0, 1'b1, 0, 1'b0});
    vecs.push_back('{10'h040, 10'h140, 10'd6, 1, 1'b0, 3, 1'b0});
    vecs.push_back('{10'h060, 10'h160, 10'd0, 0, 1'b0, 0, 1'b1});
    vecs.push_back('{10'h070, 10'h170, 10'd3, 2, 1'b0, 1, 1'b0});
    for (int k = 0; k < 8; k++) begin
      rv.in_base  = AW'($urandom);
      rv.out_base = AW'($urandom);
      rv.count    = AW'($urandom_range(0, 12));
      rv.gap      = int'($urandom_range(0, 2));
      rv.ramp     = 1'b0;
      rv.held     = int'($urandom_range(0, 3));
      rv.exp_err  = (rv.count < 3);
      vecs.push_back(rv);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {s_ready, mem_we, fir_start, done, err, busy}, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_fir", {fir_in_addr, fir_out_addr, fir_count}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) run_job(vecs[k], $sformatf("v%0d", k));

    // Reset after the third of eight beats abandons the job at once.
    @(posedge clk); #1;
    arm = 1'b1; cfg_in_base = 10'h050; cfg_out_base = 10'h150; cfg_count = 10'd8;
    @(posedge clk); #1;
    arm = 1'b0;
    for (int i = 0; i < 3; i++) present_beat(DW'(i + 10), rdy);
    check("rst_beats_taken", rdy, 1);
    rst = 1'b1; s_valid = 1'b0;
    #1;
    check("rst_ctrl", {s_ready, mem_we, fir_start, done, err, busy}, 0);
    check("rst_mem", {mem_addr, mem_data}, 0);
    check("rst_fir", {fir_in_addr, fir_out_addr, fir_count}, 0);
    n_wr = wr_addr.size();
    n_st = start_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_wr", wr_addr.size() - n_wr, 0);
    check("rst_no_start", start_cnt - n_st, 0);
    check("rst_idle", busy, 0);
    tail = '{10'h200, 10'h300, 10'd3, 0, 1'b1, 0, 1'b0};
    run_job(tail, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_loader.md
SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 Parameter ADDR_W, default 10, memory address width shared with fir_pipelined.
REQ-002 Parameter DATA_W, default 8, sample width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 arm  input  1  one-cycle request to start a load+filter job; sampled only in IDLE.
REQ-006 cfg_in_base  input  ADDR_W  input buffer base address; latched on accepted arm.
REQ-007 cfg_out_base  input  ADDR_W  output buffer base address; latched on accepted arm.
REQ-008 cfg_count  input  ADDR_W  number of samples; latched on accepted arm.
REQ-009 s_valid  input  1  upstream sample valid.
REQ-010 s_data  input  DATA_W  upstream sample.
REQ-011 s_ready  output  1  loader accepts a sample this cycle.
REQ-012 mem_addr  output  ADDR_W  write address to the sample memory load port.
REQ-013 mem_data  output  DATA_W  write data.
REQ-014 mem_we  output  1  write enable.
REQ-015 fir_start  output  1  one-cycle start pulse to the FIR.
REQ-016 fir_in_addr, fir_out_addr, fir_count  output  ADDR_W each  latched job parameters, held stable from start pulse to job end.
REQ-017 fir_done  input  1  FIR done level (stays high until the FIR's next start).
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse on job completion.
REQ-020 err  output  1  sticky; set when a job is rejected for cfg_count < 3; cleared by the next accepted arm.

Function
REQ-021 States: IDLE, LOAD, FLUSH, START, WAIT, FIN.
REQ-022 IDLE: arm=1 latches cfg_*, clears err and the sample index idx; cfg_count < 3 -> FIN with err=1 and no FIR start; otherwise -> LOAD.
REQ-023 arm outside IDLE is ignored without side effect.
REQ-024 LOAD: s_ready=1; beat accepted when s_valid&&s_ready; idx increments per accepted beat.
REQ-025 s_ready is 0 in every state except LOAD, including the cycle after the final beat is accepted.
REQ-026 Write is registered: beat accepted at edge N -> mem_we=1 during cycle N+1 with mem_addr = in_base + idx_at_accept (mod 2^ADDR_W), mem_data = that beat.
REQ-027 Address arithmetic wraps modulo 2^ADDR_W; no error is raised on wrap.
REQ-028 Accepting beat number cfg_count-1 -> FLUSH, which lasts one cycle so the last write retires -> START.
REQ-029 START: fir_start=1 for exactly one cycle -> WAIT.
REQ-030 WAIT: completion is a rising edge of fir_done (registered previous value 0, current 1); a level held high from a prior job does not complete the job; rising edge -> FIN.
REQ-031 FIN: done=1 for one cycle -> IDLE.
REQ-032 mem_we=0 in every cycle not covered by REQ-026; loader never writes during START or WAIT.
REQ-033 Gaps in s_valid stall LOAD indefinitely; no timeout.

Reset
REQ-034 On rst: state=IDLE; idx=0; s_ready, mem_we, fir_start, done, err, busy = 0; mem_addr, mem_data, fir_* = 0.
REQ-035 rst mid-job abandons the job immediately; no further writes or start pulse; the FIR is reset by the same rst.

Structure
REQ-036 ADDR_W, DATA_W defaults, minimum count (3) and state encoding belong in the shared project package used by fir_pipelined.
REQ-037 Flat single module; no sub-module. The top level muxes the memory port between loader (busy and not in WAIT) and FIR.

Verification
REQ-038 arm, in_base=0x010, out_base=0x100, count=5, samples 1..5 back-to-back -> writes addr 0x010..0x014 data 1..5; one fir_start after the last write; done 1 cycle after fir_done rises.
REQ-039 count=2 -> no s_ready, no writes, no fir_start; err=1, done pulse 1 cycle later; next arm with count=4 clears err.
REQ-040 in_base=0x3FE, count=4 -> writes to 0x3FE, 0x3FF, 0x000, 0x001.
REQ-041 fir_done held high from the previous job through fir_start -> loader stays in WAIT until fir_done falls and rises again.
REQ-042 s_valid toggling every other cycle, count=6 -> exactly 6 writes, addresses contiguous, no duplicates.
REQ-043 rst asserted after the 3rd of 8 beats -> all outputs 0 immediately; arm then accepted normally.
